// File: rtl/ov5640_pkg.sv
// Shared types and constants for the OV5640 register-table init sequencer.
package ov5640_pkg;

  localparam logic [15:0] SOFTRST_REG = 16'h3008;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_FETCH,
    ST_ROM_WAIT,
    ST_LATCH,
    ST_ISSUE,
    ST_RETRY_GAP,
    ST_CHECK,
    ST_SR_WAIT,
    ST_DONE,
    ST_ERROR
  } state_t;

  function automatic int unsigned cycles_per_us(input int unsigned clk_freq);
    return clk_freq / 1_000_000;
  endfunction

endpackage

// File: rtl/ov5640_delay_cnt.sv
// Loadable down-counter; o_done is high while the count sits at zero.
module ov5640_delay_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ov5640_init_seq.sv
// Walks the OV5640 init table, issuing each entry to the SCCB master with
// power-up / soft-reset settle delays and bounded retries on write errors.
module ov5640_init_seq
  import ov5640_pkg::*;
#(
  parameter int          CMD_NUM    = 86,
  parameter int          ADDR_WIDTH = 8,
  parameter int          DATA_WIDTH = 24,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned POWERUP_US = 20000,
  parameter int unsigned SOFTRST_US = 5000,
  parameter int          MAX_RETRY  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_rom_addr,
  input  logic [DATA_WIDTH-1:0] i_rom_q,
  output logic                  o_wr_req,
  output logic [15:0]           o_wr_addr,
  output logic [7:0]            o_wr_data,
  input  logic                  i_wr_done,
  input  logic                  i_wr_err,
  output logic                  o_init_busy,
  output logic                  o_init_done,
  output logic                  o_init_error,
  output logic [ADDR_WIDTH-1:0] o_cmd_index
);

  localparam int unsigned CPU     = cycles_per_us(CLK_FREQ);
  localparam int unsigned PWR_CYC = POWERUP_US * CPU;
  localparam int unsigned SR_CYC  = SOFTRST_US * CPU;
  localparam int unsigned MAX_CYC = (PWR_CYC > SR_CYC) ? PWR_CYC : SR_CYC;
  localparam int          CNT_W   = $clog2(MAX_CYC) + 1;
  localparam int          RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  // Counter counts down to zero inclusive, so load N-1 for an N-cycle wait.
  localparam logic [CNT_W-1:0] PWR_LOAD = CNT_W'((PWR_CYC == 0) ? 0 : PWR_CYC - 1);
  localparam logic [CNT_W-1:0] SR_LOAD  = CNT_W'((SR_CYC == 0) ? 0 : SR_CYC - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(CMD_NUM - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_start_q;
  logic                    r_start_d;
  logic [ADDR_WIDTH-1:0]   r_cmd_index;
  logic [ADDR_WIDTH-1:0]   r_rom_addr;
  logic [RTY_W-1:0]        r_retry;
  logic [15:0]             r_wr_addr;
  logic [7:0]              r_wr_data;
  logic                    w_start_rise;
  logic                    w_is_sr;
  logic                    w_last;
  logic                    w_load;
  logic [CNT_W-1:0]        w_load_val;
  logic                    w_cnt_done;

  assign w_start_rise = r_start_q & ~r_start_d;
  assign w_is_sr      = (r_wr_addr == SOFTRST_REG) & r_wr_data[7];
  assign w_last       = (r_cmd_index == LAST_IDX);

  ov5640_delay_cnt #(.W(CNT_W)) u_delay (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (w_start_rise) begin
          w_state_next = ST_PWR_WAIT;
          w_load       = 1'b1;
          w_load_val   = PWR_LOAD;
        end
      end
      ST_PWR_WAIT:  if (w_cnt_done) w_state_next = ST_FETCH;
      ST_FETCH:     w_state_next = ST_ROM_WAIT;
      ST_ROM_WAIT:  w_state_next = ST_LATCH;
      ST_LATCH:     w_state_next = ST_ISSUE;
      ST_ISSUE: begin
        // Error wins when both responses arrive together.
        if (i_wr_err) begin
          w_state_next = (r_retry == RTY_MAX) ? ST_ERROR : ST_RETRY_GAP;
        end else if (i_wr_done) begin
          w_state_next = ST_CHECK;
        end
      end
      ST_RETRY_GAP: w_state_next = ST_ISSUE;
      ST_CHECK: begin
        if (w_is_sr) begin
          w_state_next = ST_SR_WAIT;
          w_load       = 1'b1;
          w_load_val   = SR_LOAD;
        end else begin
          w_state_next = w_last ? ST_DONE : ST_FETCH;
        end
      end
      ST_SR_WAIT: if (w_cnt_done) w_state_next = w_last ? ST_DONE : ST_FETCH;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_start_q   <= 1'b0;
      r_start_d   <= 1'b0;
      r_cmd_index <= '0;
      r_rom_addr  <= '0;
      r_retry     <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_start_q <= i_start;
      r_start_d <= r_start_q;
      if (w_state_next == ST_PWR_WAIT && r_state != ST_PWR_WAIT) begin
        r_cmd_index <= '0;
        r_retry     <= '0;
      end
      if (r_state == ST_FETCH) begin
        r_rom_addr <= r_cmd_index;
      end
      if (r_state == ST_LATCH) begin
        r_wr_addr <= i_rom_q[23:8];
        r_wr_data <= i_rom_q[7:0];
      end
      if (r_state == ST_ISSUE && i_wr_err && r_retry != RTY_MAX) begin
        r_retry <= r_retry + RTY_W'(1);
      end
      if ((r_state == ST_CHECK || r_state == ST_SR_WAIT) && w_state_next == ST_FETCH) begin
        r_cmd_index <= r_cmd_index + ADDR_WIDTH'(1);
        r_retry     <= '0;
      end
    end
  end

  assign o_rom_addr   = r_rom_addr;
  assign o_wr_req     = (r_state == ST_ISSUE);
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_cmd_index  = r_cmd_index;
  assign o_init_done  = (r_state == ST_DONE);
  assign o_init_error = (r_state == ST_ERROR);
  assign o_init_busy  = !(r_state == ST_IDLE || r_state == ST_DONE || r_state == ST_ERROR);

endmodule

// File: tb/tb_ov5640_init_seq.sv
// Directed bench for ov5640_init_seq: registered ROM model, SCCB responder
// with scripted NACKs, and per-scenario tasks with hand-computed expectations.
module tb_ov5640_init_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rom_addr;
  logic [23:0] rom_q = 24'h0;
  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_done = 1'b0;
  logic        wr_err = 1'b0;
  logic        busy, done, err;
  logic [7:0]  cmd_index;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [23:0] tbl [0:2];
  logic [23:0] wlog [$];
  int          resp_cyc [$];
  int          rise_cyc [$];
  logic [15:0] err_addr = 16'h0;
  int          err_left = 0;
  bit          both_first = 1'b0;

  ov5640_init_seq #(
    .CMD_NUM(3), .ADDR_WIDTH(8), .DATA_WIDTH(24), .CLK_FREQ(1_000_000),
    .POWERUP_US(10), .SOFTRST_US(50), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .i_start(start),
    .o_rom_addr(rom_addr), .i_rom_q(rom_q),
    .o_wr_req(wr_req), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
    .i_wr_done(wr_done), .i_wr_err(wr_err),
    .o_init_busy(busy), .o_init_done(done), .o_init_error(err),
    .o_cmd_index(cmd_index)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= (rom_addr < 8'd3) ? tbl[rom_addr[1:0]] : 24'h0;

  // SCCB responder: answers 4 negedges after wr_req rises.
  initial begin : responder
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      wr_done = 1'b0;
      wr_err  = 1'b0;
      if (reset || !wr_req) begin
        wcnt = 0;
      end else begin
        wcnt++;
        if (wcnt == 4) begin
          wlog.push_back({wr_addr, wr_data});
          resp_cyc.push_back(cyc);
          if (wr_addr == err_addr && err_left > 0) begin
            err_left--;
            wr_err = 1'b1;
            if (both_first) begin
              wr_done = 1'b1;
              both_first = 1'b0;
            end
          end else begin
            wr_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin : monitor
    logic        prev_req;
    logic [23:0] prev_ad;
    prev_req = 1'b0;
    prev_ad  = 24'h0;
    forever begin
      @(negedge clk);
      if (wr_req && !prev_req) rise_cyc.push_back(cyc);
      if (wr_req && prev_req && {wr_addr, wr_data} !== prev_ad) begin
        failures++;
        $display("FAIL wr_stable got=%h exp=%h", {wr_addr, wr_data}, prev_ad);
      end
      prev_req = wr_req;
      prev_ad  = {wr_addr, wr_data};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs;
    wlog.delete();
    resp_cyc.delete();
    rise_cyc.delete();
  endtask

  task automatic do_start;
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    repeat (3) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done || err) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_req, busy, done, err} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {wr_req, busy, done, err});
    end
    checks++;
    if ({cmd_index, rom_addr} !== 16'h0) begin
      failures++;
      $display("FAIL reset_index got=%h exp=0000", {cmd_index, rom_addr});
    end
    checks++;
    if ({wr_addr, wr_data} !== 24'h0) begin
      failures++;
      $display("FAIL reset_wr got=%h exp=000000", {wr_addr, wr_data});
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    logic [23:0] got;
    clear_logs();
    do_start();
    wait_end(400, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got=0 exp=1"); end
    checks++;
    if ({done, err, busy} !== 3'b100) begin
      failures++;
      $display("FAIL basic_status got=%b exp=100", {done, err, busy});
    end
    checks++;
    if (cmd_index !== 8'd2) begin failures++; $display("FAIL basic_index got=%0d exp=2", cmd_index); end
    checks++;
    if (wlog.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", wlog.size()); end
    for (int k = 0; k < 3; k++) begin
      got = (k < wlog.size()) ? wlog[k] : 24'hx;
      checks++;
      if (got !== tbl[k]) begin failures++; $display("FAIL basic_entry%0d got=%h exp=%h", k, got, tbl[k]); end
    end
    // start accepted 2 edges after it rises, 10 wait cycles, then FETCH/ROM_WAIT/LATCH.
    checks++;
    got = (rise_cyc.size() > 0) ? 24'(rise_cyc[0] - start_cyc) : 24'hx;
    if (got !== 24'd15) begin failures++; $display("FAIL powerup_gap got=%0d exp=15", got); end
  endtask

  task automatic test_softreset;
    bit ok;
    int gap;
    tbl[0] = 24'h300882;
    clear_logs();
    do_start();
    wait_end(600, ok);
    checks++;
    if (!ok || done !== 1'b1 || wlog.size() != 3) begin
      failures++;
      $display("FAIL sr_complete got=%0b/%0d exp=1/3", done, wlog.size());
    end
    gap = (rise_cyc.size() > 1 && resp_cyc.size() > 0) ? rise_cyc[1] - resp_cyc[0] : -1;
    checks++;
    if (gap != 55) begin failures++; $display("FAIL sr_gap got=%0d exp=55", gap); end
    checks++;
    if (wlog.size() < 2 || wlog[1] !== tbl[1]) begin
      failures++;
      $display("FAIL sr_next_entry got=%h exp=%h", (wlog.size() > 1) ? wlog[1] : 24'hx, tbl[1]);
    end
    tbl[0] = 24'h300802;
    clear_logs();
    do_start();
    wait_end(600, ok);
    gap = (rise_cyc.size() > 1 && resp_cyc.size() > 0) ? rise_cyc[1] - resp_cyc[0] : -1;
    checks++;
    if (!ok || gap != 5) begin failures++; $display("FAIL nosr_gap got=%0d exp=5", gap); end
    tbl[0] = 24'h310303;
  endtask

  task automatic test_retry;
    bit ok;
    int n;
    int gap;
    err_addr = 16'h3017;
    err_left = 2;
    both_first = 1'b1;
    clear_logs();
    do_start();
    wait_end(600, ok);
    checks++;
    if (!ok || {done, err} !== 2'b10) begin
      failures++;
      $display("FAIL retry_status got=%b exp=10", {done, err});
    end
    n = 0;
    foreach (wlog[k]) if (wlog[k] === tbl[1]) n++;
    checks++;
    if (n != 3 || wlog.size() != 5) begin
      failures++;
      $display("FAIL retry_writes got=%0d/%0d exp=3/5", n, wlog.size());
    end
    gap = (rise_cyc.size() > 2 && resp_cyc.size() > 1) ? rise_cyc[2] - resp_cyc[1] : -1;
    checks++;
    if (gap != 2) begin failures++; $display("FAIL retry_gap got=%0d exp=2", gap); end
  endtask

  task automatic test_error;
    bit ok;
    err_addr = 16'h3017;
    err_left = 4;
    both_first = 1'b0;
    clear_logs();
    do_start();
    wait_end(600, ok);
    checks++;
    if (!ok || {err, done, busy, wr_req} !== 4'b1000) begin
      failures++;
      $display("FAIL error_status got=%b exp=1000", {err, done, busy, wr_req});
    end
    checks++;
    if (cmd_index !== 8'd1) begin failures++; $display("FAIL error_index got=%0d exp=1", cmd_index); end
    repeat (30) @(negedge clk);
    checks++;
    if (wlog.size() != 5 || err !== 1'b1) begin
      failures++;
      $display("FAIL error_held got=%0d/%0b exp=5/1", wlog.size(), err);
    end
    err_left = 0;
    clear_logs();
    do_start();
    wait_end(600, ok);
    checks++;
    if (!ok || done !== 1'b1 || wlog.size() != 3 || wlog[0] !== tbl[0]) begin
      failures++;
      $display("FAIL error_restart got=%0b/%0d exp=1/3", done, wlog.size());
    end
  endtask

  task automatic test_start_ignored;
    bit ok;
    clear_logs();
    do_start();
    repeat (20) @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_end(600, ok);
    checks++;
    if (!ok || wlog.size() != 3 || rise_cyc.size() != 3) begin
      failures++;
      $display("FAIL busy_start got=%0d/%0d exp=3/3", wlog.size(), rise_cyc.size());
    end
    checks++;
    if (wlog.size() < 3 || wlog[2] !== tbl[2] || cmd_index !== 8'd2) begin
      failures++;
      $display("FAIL busy_start_last got=%0d exp=2", cmd_index);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    bit found;
    clear_logs();
    do_start();
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (wr_req && wr_addr == tbl[2][23:8]) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin failures++; $display("FAIL rstmid_reach got=0 exp=1"); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({wr_req, busy, done, err} !== 4'b0000 || cmd_index !== 8'd0 || {wr_addr, wr_data} !== 24'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%0d/%h exp=0000/0/000000",
               {wr_req, busy, done, err}, cmd_index, {wr_addr, wr_data});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clear_logs();
    do_start();
    wait_end(600, ok);
    checks++;
    if (!ok || done !== 1'b1 || wlog.size() != 3 || wlog[0] !== tbl[0]) begin
      failures++;
      $display("FAIL rstmid_restart got=%0b/%0d exp=1/3", done, wlog.size());
    end
  endtask

  initial begin
    tbl[0] = 24'h310303;
    tbl[1] = 24'h3017ff;
    tbl[2] = 24'h430003;
    test_reset();
    test_basic();
    test_softreset();
    test_retry();
    test_error();
    test_start_ignored();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
